// File: rtl/gpi_event_pkg.sv
// Shared register map and prescaler sizing for the debounced GPI event core.
package gpi_event_pkg;

    localparam logic [4:0] REG_DATA   = 5'd0;
    localparam logic [4:0] REG_RAW    = 5'd1;
    localparam logic [4:0] REG_IE     = 5'd2;
    localparam logic [4:0] REG_RISE   = 5'd3;
    localparam logic [4:0] REG_FALL   = 5'd4;
    localparam logic [4:0] REG_STATUS = 5'd5;
    localparam logic [4:0] REG_DBP    = 5'd6;

    localparam int PRESC_W = 16;

endpackage

// File: rtl/gpi_debounce.sv
// One input bit: 2-flop synchronizer followed by a tick-driven debounce filter
// that reports a single-cycle pulse on the edge where a new level commits.
module gpi_debounce #(
    parameter int DB_COUNT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic tick,
    output logic raw_s,
    output logic lvl,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int              CW       = $clog2(DB_COUNT) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DB_COUNT - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          lvl_q, lvl_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          commit;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        commit = 1'b0;
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        if (sync2_q == lvl_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
                commit = 1'b1;
                lvl_d  = sync2_q;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pulses are combinational so STATUS can set on the same edge lvl changes.
    assign raw_s      = sync2_q;
    assign lvl        = lvl_q;
    assign rise_pulse = commit & sync2_q;
    assign fall_pulse = commit & ~sync2_q;

endmodule

// File: rtl/gpi_event_ctrl.sv
// MMIO slot GPI core: debounced inputs, per-bit edge capture into W1C status,
// and a level interrupt from enabled status bits.
module gpi_event_ctrl
    import gpi_event_pkg::*;
#(
    parameter int W             = 8,
    parameter int DB_COUNT      = 8,
    parameter int DB_PERIOD_RST = 999
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [W-1:0] din,
    output logic         irq
);

    logic [W-1:0]       raw_s, lvl, rise, fall;
    logic [W-1:0]       ie_q, ie_d;
    logic [W-1:0]       rise_en_q, rise_en_d;
    logic [W-1:0]       fall_en_q, fall_en_d;
    logic [W-1:0]       status_q, status_d;
    logic [PRESC_W-1:0] db_period_q, db_period_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick;
    logic               wr_en;
    logic               unused_ok;

    assign wr_en     = cs & write;
    assign tick      = (presc_q == db_period_q);
    assign unused_ok = ^{read, wr_data};

    for (genvar i = 0; i < W; i++) begin : g_bit
        gpi_debounce #(.DB_COUNT(DB_COUNT)) u_db (
            .clk        (clk),
            .reset      (reset),
            .din        (din[i]),
            .tick       (tick),
            .raw_s      (raw_s[i]),
            .lvl        (lvl[i]),
            .rise_pulse (rise[i]),
            .fall_pulse (fall[i])
        );
    end

    always_comb begin
        ie_d        = ie_q;
        rise_en_d   = rise_en_q;
        fall_en_d   = fall_en_q;
        db_period_d = db_period_q;
        presc_d     = tick ? '0 : presc_q + PRESC_W'(1);
        status_d    = status_q;

        if (wr_en) begin
            case (addr)
                REG_IE:     ie_d      = wr_data[W-1:0];
                REG_RISE:   rise_en_d = wr_data[W-1:0];
                REG_FALL:   fall_en_d = wr_data[W-1:0];
                REG_STATUS: status_d  = status_q & ~wr_data[W-1:0];
                REG_DBP: begin
                    db_period_d = wr_data[PRESC_W-1:0];
                    presc_d     = '0;
                end
                default: ;
            endcase
        end

        // Applied after the clear so a same-cycle commit keeps its flag.
        status_d = status_d | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ie_q        <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            status_q    <= '0;
            db_period_q <= PRESC_W'(DB_PERIOD_RST);
            presc_q     <= '0;
        end else begin
            ie_q        <= ie_d;
            rise_en_q   <= rise_en_d;
            fall_en_q   <= fall_en_d;
            status_q    <= status_d;
            db_period_q <= db_period_d;
            presc_q     <= presc_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_DATA:   rd_data = 32'(lvl);
            REG_RAW:    rd_data = 32'(raw_s);
            REG_IE:     rd_data = 32'(ie_q);
            REG_RISE:   rd_data = 32'(rise_en_q);
            REG_FALL:   rd_data = 32'(fall_en_q);
            REG_STATUS: rd_data = 32'(status_q);
            REG_DBP:    rd_data = 32'(db_period_q);
            default:    rd_data = '0;
        endcase
    end

    assign irq = |(status_q & ie_q);

endmodule

// File: tb/tb_gpi_event_ctrl.sv
// Directed bench for gpi_event_ctrl with W=8, DB_COUNT=4, DB_PERIOD reset 999.
module tb_gpi_event_ctrl;
    import gpi_event_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs, read, write;
    logic [4:0]  addr;
    logic [31:0] wr_data, rd_data;
    logic [7:0]  din;
    logic        irq;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    gpi_event_ctrl #(.W(8), .DB_COUNT(4), .DB_PERIOD_RST(999)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .din     (din),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] d);
        cs = 1'b1; read = 1'b1; addr = a;
        #1;
        d = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        logic [31:0] exp;
        for (int a = 0; a <= 6; a++) begin
            do_read(5'(a), v);
            exp = (a == 6) ? 32'd999 : 32'd0;
            chk_cnt++;
            if (v !== exp) $display("FAIL reset_reg%0d: got %h expected %h", a, v, exp);
            else pass_cnt++;
        end
        chk_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq);
        else pass_cnt++;
    endtask

    task automatic test_rise_irq;
        logic [31:0] v;
        do_write(REG_DBP, 32'd0);
        do_write(REG_RISE, 32'h01);
        do_write(REG_IE, 32'h01);
        din = 8'h01;
        repeat (5) @(negedge clk);
        do_read(REG_DATA, v);
        chk_cnt++;
        if (v !== 32'h0 || irq !== 1'b0) $display("FAIL rise_early: data %h irq %b expected 0/0", v, irq);
        else pass_cnt++;
        @(negedge clk);
        do_read(REG_DATA, v);
        chk_cnt++;
        if (v !== 32'h01) $display("FAIL rise_data: got %h expected 01", v);
        else pass_cnt++;
        do_read(REG_STATUS, v);
        chk_cnt++;
        if (v !== 32'h01) $display("FAIL rise_status: got %h expected 01", v);
        else pass_cnt++;
        chk_cnt++;
        if (irq !== 1'b1) $display("FAIL rise_irq: got %b expected 1", irq);
        else pass_cnt++;
        do_read(REG_RAW, v);
        chk_cnt++;
        if (v !== 32'h01) $display("FAIL rise_raw: got %h expected 01", v);
        else pass_cnt++;
        do_write(REG_STATUS, 32'h01);
        do_read(REG_STATUS, v);
        chk_cnt++;
        if (v !== 32'h0 || irq !== 1'b0) $display("FAIL w1c_clear: status %h irq %b expected 0/0", v, irq);
        else pass_cnt++;
    endtask

    task automatic test_glitch;
        logic [31:0] v;
        do_write(REG_RISE, 32'h03);
        din = 8'h03;
        repeat (3) @(negedge clk);
        din = 8'h01;
        repeat (10) @(negedge clk);
        do_read(REG_DATA, v);
        chk_cnt++;
        if (v !== 32'h01) $display("FAIL glitch_data: got %h expected 01", v);
        else pass_cnt++;
        do_read(REG_STATUS, v);
        chk_cnt++;
        if (v !== 32'h0) $display("FAIL glitch_status: got %h expected 0", v);
        else pass_cnt++;
    endtask

    task automatic test_fall_prescaled;
        logic [31:0] v;
        int n;
        do_write(REG_RISE, 32'h0);
        din = 8'h05;
        repeat (40) @(negedge clk);
        do_read(REG_DATA, v);
        chk_cnt++;
        if (v !== 32'h05) $display("FAIL fall_settle: got %h expected 05", v);
        else pass_cnt++;
        do_write(REG_DBP, 32'd2);
        do_write(REG_FALL, 32'h04);
        din = 8'h01;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            n++;
            do_read(REG_DATA, v);
            if (v[2] == 1'b0) break;
        end
        chk_cnt++;
        if (v[2] !== 1'b0 || n < 12 || n > 16) $display("FAIL fall_latency: got %0d cycles expected 12..16", n);
        else pass_cnt++;
        do_read(REG_STATUS, v);
        chk_cnt++;
        if (v !== 32'h04) $display("FAIL fall_status: got %h expected 04", v);
        else pass_cnt++;
        chk_cnt++;
        if (irq !== 1'b0) $display("FAIL fall_irq_masked: got %b expected 0", irq);
        else pass_cnt++;
    endtask

    task automatic test_w1c_vs_set;
        logic [31:0] v;
        do_write(REG_DBP, 32'd0);
        do_write(REG_STATUS, 32'hFF);
        do_write(REG_RISE, 32'h01);
        din = 8'h00;
        repeat (10) @(negedge clk);
        do_read(REG_STATUS, v);
        chk_cnt++;
        if (v !== 32'h0) $display("FAIL collide_pre_status: got %h expected 0", v);
        else pass_cnt++;
        din = 8'h01;
        repeat (5) @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = REG_STATUS; wr_data = 32'h01;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; wr_data = '0;
        do_read(REG_STATUS, v);
        chk_cnt++;
        if (v !== 32'h01) $display("FAIL collide_set_wins: got %h expected 01", v);
        else pass_cnt++;
        chk_cnt++;
        if (irq !== 1'b1) $display("FAIL collide_irq: got %b expected 1", irq);
        else pass_cnt++;
        do_write(REG_STATUS, 32'h01);
        do_read(REG_STATUS, v);
        chk_cnt++;
        if (v !== 32'h0) $display("FAIL collide_clear: got %h expected 0", v);
        else pass_cnt++;
    endtask

    task automatic test_unmapped;
        logic [31:0] v;
        logic [31:0] exp [7];
        for (int a = 7; a < 32; a++) begin
            do_read(5'(a), v);
            chk_cnt++;
            if (v !== 32'h0) $display("FAIL unmapped_rd%0d: got %h expected 0", a, v);
            else pass_cnt++;
        end
        do_write(REG_DATA, 32'hFFFF_FFFF);
        do_write(REG_RAW, 32'hFFFF_FFFF);
        do_write(5'd7, 32'hFFFF_FFFF);
        do_write(5'd31, 32'hFFFF_FFFF);
        exp = '{32'h01, 32'h01, 32'h01, 32'h01, 32'h04, 32'h00, 32'h00};
        for (int a = 0; a <= 6; a++) begin
            do_read(5'(a), v);
            chk_cnt++;
            if (v !== exp[a]) $display("FAIL ro_write_reg%0d: got %h expected %h", a, v, exp[a]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        int n;
        din = 8'h11;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        do_read(REG_DATA, v);
        chk_cnt++;
        if (v !== 32'h0) $display("FAIL rst_mid_data: got %h expected 0", v);
        else pass_cnt++;
        do_read(REG_DBP, v);
        chk_cnt++;
        if (v !== 32'd999) $display("FAIL rst_mid_dbp: got %0d expected 999", v);
        else pass_cnt++;
        do_read(REG_IE, v);
        chk_cnt++;
        if (v !== 32'h0 || irq !== 1'b0) $display("FAIL rst_mid_ie: ie %h irq %b expected 0/0", v, irq);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 4200; i++) begin
            @(negedge clk);
            n++;
            do_read(REG_DATA, v);
            if (v[4] == 1'b1) break;
        end
        chk_cnt++;
        if (v[4] !== 1'b1 || n != 4000) $display("FAIL rst_hold_commit: got %0d cycles expected 4000", n);
        else pass_cnt++;
        chk_cnt++;
        if (v !== 32'h11) $display("FAIL rst_hold_data: got %h expected 11", v);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0; cs = 1'b0; read = 1'b0; write = 1'b0;
        addr = '0; wr_data = '0; din = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_rise_irq();
        test_glitch();
        test_fall_prescaled();
        test_w1c_vs_set();
        test_unmapped();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
